pong_game_ctrl: RTL and testbench
=================================

# pong_game_ctrl

Game-sequencing controller for the Pong datapath. It owns the ball animator's `animate` and reset inputs and watches the ball edge coordinates against both paddles. From these it runs the serve, rally, point and game-over sequence and keeps both players' scores. It sits between the ball animator, the paddle logic and the VGA overlay that draws scores and status.

## Interface
Parameters:
- `D_WIDTH`, 640: screen width in pixels.
- `MISS_MARGIN`, 2: ball left edge `<= MISS_MARGIN` or right edge `>= D_WIDTH-1-MISS_MARGIN` is a wall contact.
- `SERVE_FRAMES`, 60: animation strobes spent in SERVE before play.
- `POINT_FRAMES`, 90: animation strobes spent in POINT after a miss.
- `WIN_SCORE`, 7: score that ends the game (1..15).

Ports:
- `i_clk` in 1: base clock; the only clock.
- `i_rst` in 1: synchronous, active-high reset.
- `i_ani_stb` in 1: one-cycle frame strobe, the same strobe that drives the ball animator.
- `i_start` in 1: start/serve button, level, already debounced.
- `i_bx1`, `i_bx2`, `i_by1`, `i_by2` in 12 each: ball left, right, top and bottom edges.
- `i_lp_y1`, `i_lp_y2` in 12 each: left paddle top and bottom.
- `i_rp_y1`, `i_rp_y2` in 12 each: right paddle top and bottom.
- `o_animate` out 1: drives the ball animator's `i_animate`.
- `o_ball_rst` out 1: drives the ball animator's `i_rst`; one-cycle pulse.
- `o_score_l`, `o_score_r` out 4 each: player scores.
- `o_state` out 3: 0 IDLE, 1 SERVE, 2 PLAY, 3 POINT, 4 OVER.
- `o_winner` out 2: 00 none, 01 left, 10 right.

## Operation
- All outputs are registered.
- Reset values: state IDLE, `o_animate`=0, `o_ball_rst`=0, scores 0, `o_winner`=00, frame counter 0, start-edge register 0.
- Start edge: `start_rise = i_start & ~start_q`. `start_q` is registered every cycle.
- Overlap: `ov_l = (i_by2 >= i_lp_y1) && (i_by1 <= i_lp_y2)`. `ov_r` is the same test against the right paddle. Comparisons are unsigned 12-bit.
- Miss conditions: `miss_l = (i_bx1 <= MISS_MARGIN) && !ov_l`, which scores for the right player. `miss_r = (i_bx2 >= D_WIDTH-1-MISS_MARGIN) && !ov_r`, which scores for the left player. A wall contact with overlap is a hit; nothing happens and the animator bounces the ball.

State transitions:
- IDLE: on `start_rise`, clear scores, set `o_winner`=00, pulse `o_ball_rst`, clear the counter, go to SERVE.
- SERVE: count `i_ani_stb` pulses. On the strobe where counter == `SERVE_FRAMES-1`, go to PLAY and clear the counter.
- PLAY: `o_animate`=1. Misses are evaluated only on cycles with `i_ani_stb`=1.
  - On `miss_l`, increment `o_score_r`; `miss_l` has priority if both are true.
  - On `miss_r`, increment `o_score_l`.
  - After a miss: if the new score == `WIN_SCORE`, set `o_winner` and go to OVER; otherwise go to POINT. Clear the counter.
- POINT: count strobes. On counter == `POINT_FRAMES-1`, pulse `o_ball_rst` and go to SERVE.
- OVER: hold scores and winner. On `start_rise`, act exactly as the IDLE start.
- Scores never exceed `WIN_SCORE`; no wrap-around is possible.
- `start_rise` is ignored in SERVE, PLAY and POINT.
- `i_rst` in any state, including mid-countdown or mid-pulse, forces the reset values on the next edge and overrides every other input.

## Timing
- `o_animate` rises on the edge that enters PLAY. It falls on the same edge that registers the miss and updates the score, so the animator receives no further strobe-qualified step after the miss frame.
- `o_ball_rst` is high for exactly one cycle, the cycle after the transition edge into SERVE.
- SERVE lasts exactly `SERVE_FRAMES` strobes. POINT lasts `POINT_FRAMES` strobes.
- Start latency: IDLE to SERVE is 1 cycle after the `i_start` rising edge is sampled.
- Miss latency: 1 cycle from the sampling strobe to the score and state update.
- A score updates at most once per strobe. The counter is at least 7 bits and sized from `max(SERVE_FRAMES, POINT_FRAMES)`.

## Test plan
- Reset, then `i_start` 0→1 → `o_state`=1 one cycle later. `o_ball_rst` is high exactly 1 cycle. Scores are 0.
- In SERVE, issue 60 strobes → `o_state`=2 and `o_animate`=1 after the 60th, not earlier.
- In PLAY, set `i_bx1`=1, ball y 100..140, left paddle 300..380, apply a strobe → `o_score_r`=1, `o_state`=3, `o_animate`=0. After 90 strobes → `o_ball_rst` pulse and `o_state`=1.
- In PLAY, set `i_bx1`=1 with left paddle 90..170 (overlap) → no score change; stays in PLAY. Also check that the same miss inputs without a strobe leave the state unchanged.
- Run the right player to 7 misses → `o_score_l`=7, `o_winner`=01, `o_state`=4. Holding `i_start` high gives no restart; releasing and re-pressing returns scores to 0 and `o_state` to 1.
- Assert `i_rst` mid-POINT and on the same cycle as a miss strobe → next edge shows all reset values and no score increment.

Source files
------------

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: game sequencer for the Pong datapath.
// Runs the idle -> serve -> play -> point/over sequence, owns the ball animator's
// animate and reset inputs, and keeps both players' scores.
//
// Ports:
//   i_clk, i_rst        clock; synchronous active-high reset
//   i_ani_stb           one-cycle frame strobe (shared with the ball animator)
//   i_start             debounced start/serve button (level)
//   i_bx1/i_bx2         ball left/right edge
//   i_by1/i_by2         ball top/bottom edge
//   i_lp_y1/i_lp_y2     left paddle top/bottom
//   i_rp_y1/i_rp_y2     right paddle top/bottom
//   o_animate           ball animator enable
//   o_ball_rst          one-cycle ball animator reset pulse
//   o_score_l/o_score_r player scores
//   o_state             0 idle, 1 serve, 2 play, 3 point, 4 over
//   o_winner            00 none, 01 left, 10 right
module pong_game_ctrl #(
  parameter int unsigned D_WIDTH      = 640,
  parameter int unsigned MISS_MARGIN  = 2,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 90,
  parameter int unsigned WIN_SCORE    = 7
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ani_stb,
  input  logic        i_start,
  input  logic [11:0] i_bx1,
  input  logic [11:0] i_bx2,
  input  logic [11:0] i_by1,
  input  logic [11:0] i_by2,
  input  logic [11:0] i_lp_y1,
  input  logic [11:0] i_lp_y2,
  input  logic [11:0] i_rp_y1,
  input  logic [11:0] i_rp_y2,
  output logic        o_animate,
  output logic        o_ball_rst,
  output logic [3:0]  o_score_l,
  output logic [3:0]  o_score_r,
  output logic [2:0]  o_state,
  output logic [1:0]  o_winner
);

  localparam int unsigned MaxFrames = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int unsigned CntW      = ($clog2(MaxFrames) > 7) ? $clog2(MaxFrames) : 7;

  localparam logic [11:0]     LeftWall  = 12'(MISS_MARGIN);
  localparam logic [11:0]     RightWall = 12'(D_WIDTH - 1 - MISS_MARGIN);
  localparam logic [CntW-1:0] ServeLast = CntW'(SERVE_FRAMES - 1);
  localparam logic [CntW-1:0] PointLast = CntW'(POINT_FRAMES - 1);
  localparam logic [3:0]      WinScore  = 4'(WIN_SCORE);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StServe = 3'd1,
    StPlay  = 3'd2,
    StPoint = 3'd3,
    StOver  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      score_l_q, score_l_d;
  logic [3:0]      score_r_q, score_r_d;
  logic [1:0]      winner_q, winner_d;
  logic            animate_q, animate_d;
  logic            ball_rst_q, ball_rst_d;
  logic            start_q;

  logic       start_rise;
  logic       ov_l, ov_r;
  logic       miss_l, miss_r;
  logic [3:0] score_l_inc, score_r_inc;

  assign start_rise  = i_start & ~start_q;
  assign ov_l        = (i_by2 >= i_lp_y1) && (i_by1 <= i_lp_y2);
  assign ov_r        = (i_by2 >= i_rp_y1) && (i_by1 <= i_rp_y2);
  assign miss_l      = (i_bx1 <= LeftWall) && !ov_l;
  assign miss_r      = (i_bx2 >= RightWall) && !ov_r;
  assign score_l_inc = score_l_q + 4'd1;
  assign score_r_inc = score_r_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    score_l_d  = score_l_q;
    score_r_d  = score_r_q;
    winner_d   = winner_q;
    ball_rst_d = 1'b0;

    unique case (state_q)
      StIdle, StOver: begin
        if (start_rise) begin
          score_l_d  = 4'd0;
          score_r_d  = 4'd0;
          winner_d   = 2'b00;
          ball_rst_d = 1'b1;
          cnt_d      = '0;
          state_d    = StServe;
        end
      end
      StServe: begin
        if (i_ani_stb) begin
          if (cnt_q == ServeLast) begin
            cnt_d   = '0;
            state_d = StPlay;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StPlay: begin
        // A left-wall miss wins the tie when both walls report a miss.
        if (i_ani_stb && miss_l) begin
          score_r_d = score_r_inc;
          cnt_d     = '0;
          if (score_r_inc == WinScore) begin
            winner_d = 2'b10;
            state_d  = StOver;
          end else begin
            state_d = StPoint;
          end
        end else if (i_ani_stb && miss_r) begin
          score_l_d = score_l_inc;
          cnt_d     = '0;
          if (score_l_inc == WinScore) begin
            winner_d = 2'b01;
            state_d  = StOver;
          end else begin
            state_d = StPoint;
          end
        end
      end
      StPoint: begin
        if (i_ani_stb) begin
          if (cnt_q == PointLast) begin
            cnt_d      = '0;
            ball_rst_d = 1'b1;
            state_d    = StServe;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Registered from the next state so animate drops on the same edge as the miss.
    animate_d = (state_d == StPlay);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      score_l_q  <= 4'd0;
      score_r_q  <= 4'd0;
      winner_q   <= 2'b00;
      animate_q  <= 1'b0;
      ball_rst_q <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      score_l_q  <= score_l_d;
      score_r_q  <= score_r_d;
      winner_q   <= winner_d;
      animate_q  <= animate_d;
      ball_rst_q <= ball_rst_d;
      start_q    <= i_start;
    end
  end

  assign o_animate  = animate_q;
  assign o_ball_rst = ball_rst_q;
  assign o_score_l  = score_l_q;
  assign o_score_r  = score_r_q;
  assign o_state    = state_q;
  assign o_winner   = winner_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl; expectations are queued as stimulus is applied
// and drained against the DUT outputs once they are observable.
module tb_pong_game_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_ani_stb;
  logic        i_start;
  logic [11:0] i_bx1, i_bx2, i_by1, i_by2;
  logic [11:0] i_lp_y1, i_lp_y2, i_rp_y1, i_rp_y2;
  logic        o_animate, o_ball_rst;
  logic [3:0]  o_score_l, o_score_r;
  logic [2:0]  o_state;
  logic [1:0]  o_winner;

  always #5 i_clk = ~i_clk;

  pong_game_ctrl dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_ani_stb  (i_ani_stb),
    .i_start    (i_start),
    .i_bx1      (i_bx1),
    .i_bx2      (i_bx2),
    .i_by1      (i_by1),
    .i_by2      (i_by2),
    .i_lp_y1    (i_lp_y1),
    .i_lp_y2    (i_lp_y2),
    .i_rp_y1    (i_rp_y1),
    .i_rp_y2    (i_rp_y2),
    .o_animate  (o_animate),
    .o_ball_rst (o_ball_rst),
    .o_score_l  (o_score_l),
    .o_score_r  (o_score_r),
    .o_state    (o_state),
    .o_winner   (o_winner)
  );

  localparam int SelState = 0;
  localparam int SelAnim  = 1;
  localparam int SelBrst  = 2;
  localparam int SelSl    = 3;
  localparam int SelSr    = 4;
  localparam int SelWin   = 5;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] obs_of(input int sel);
    case (sel)
      SelState: obs_of = 32'(o_state);
      SelAnim:  obs_of = 32'(o_animate);
      SelBrst:  obs_of = 32'(o_ball_rst);
      SelSl:    obs_of = 32'(o_score_l);
      SelSr:    obs_of = 32'(o_score_r);
      default:  obs_of = 32'(o_winner);
    endcase
  endfunction

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = obs_of(e.sel);
      n_cmp++;
      assert (obs === e.exp)
      else begin
        n_err++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  // n spaced strobes; returns one idle cycle after the last one.
  task automatic strobe(input int n);
    repeat (n) begin
      i_ani_stb = 1'b1;
      @(negedge i_clk);
      i_ani_stb = 1'b0;
      @(negedge i_clk);
    end
  endtask

  // Single strobe returning right after the consuming edge, to catch one-cycle pulses.
  task automatic last_strobe();
    i_ani_stb = 1'b1;
    @(negedge i_clk);
    i_ani_stb = 1'b0;
  endtask

  initial begin
    i_rst     = 1'b1;
    i_ani_stb = 1'b0;
    i_start   = 1'b0;
    i_bx1     = 12'd300;
    i_bx2     = 12'd310;
    i_by1     = 12'd100;
    i_by2     = 12'd140;
    i_lp_y1   = 12'd300;
    i_lp_y2   = 12'd380;
    i_rp_y1   = 12'd300;
    i_rp_y2   = 12'd380;

    step(2);
    push("rst_state", SelState, 0);
    push("rst_anim", SelAnim, 0);
    push("rst_brst", SelBrst, 0);
    push("rst_sl", SelSl, 0);
    push("rst_sr", SelSr, 0);
    push("rst_win", SelWin, 0);
    drain();
    i_rst = 1'b0;
    step(1);

    // Start press: SERVE one cycle later with a one-cycle ball reset.
    i_start = 1'b1;
    push("start_state", SelState, 1);
    push("start_brst", SelBrst, 1);
    push("start_sl", SelSl, 0);
    push("start_sr", SelSr, 0);
    push("start_win", SelWin, 0);
    step(1);
    drain();
    push("start_brst_fall", SelBrst, 0);
    push("start_state_hold", SelState, 1);
    step(1);
    drain();

    // Serve countdown: 59 strobes stay in SERVE, the 60th enters PLAY.
    strobe(59);
    push("serve59_state", SelState, 1);
    push("serve59_anim", SelAnim, 0);
    drain();
    last_strobe();
    push("serve60_state", SelState, 2);
    push("serve60_anim", SelAnim, 1);
    drain();
    step(1);

    // Just outside the margin is not a wall contact.
    i_bx1 = 12'd3;
    strobe(1);
    push("margin_plus1_state", SelState, 2);
    push("margin_plus1_sr", SelSr, 0);
    drain();

    // Miss inputs at the margin but no strobe: nothing changes.
    i_bx1 = 12'd2;
    step(3);
    push("nostb_state", SelState, 2);
    push("nostb_sr", SelSr, 0);
    drain();

    // Wall contact with paddle overlap is a hit.
    i_lp_y1 = 12'd90;
    i_lp_y2 = 12'd170;
    strobe(1);
    push("hit_state", SelState, 2);
    push("hit_sr", SelSr, 0);
    push("hit_anim", SelAnim, 1);
    drain();

    // Left miss scores for the right player.
    i_lp_y1 = 12'd300;
    i_lp_y2 = 12'd380;
    strobe(1);
    i_bx1 = 12'd300;
    push("missl_sr", SelSr, 1);
    push("missl_state", SelState, 3);
    push("missl_anim", SelAnim, 0);
    drain();

    // Point countdown ends with a ball reset pulse back into SERVE.
    strobe(89);
    push("point89_state", SelState, 3);
    push("point89_brst", SelBrst, 0);
    drain();
    last_strobe();
    push("point90_state", SelState, 1);
    push("point90_brst", SelBrst, 1);
    drain();
    step(1);
    push("point_brst_fall", SelBrst, 0);
    drain();

    // Right-wall misses at the exact threshold until the left player wins.
    for (int k = 1; k <= 7; k++) begin
      strobe(60);
      push($sformatf("round%0d_play", k), SelState, 2);
      drain();
      i_bx2 = 12'd637;
      strobe(1);
      i_bx2 = 12'd310;
      push($sformatf("round%0d_sl", k), SelSl, 32'(k));
      push($sformatf("round%0d_state", k), SelState, (k == 7) ? 4 : 3);
      push($sformatf("round%0d_win", k), SelWin, (k == 7) ? 1 : 0);
      drain();
      if (k < 7) strobe(90);
    end
    push("over_sr", SelSr, 1);
    drain();

    // Held start gives no restart; a fresh press does.
    step(3);
    push("over_hold_state", SelState, 4);
    push("over_hold_sl", SelSl, 7);
    drain();
    i_start = 1'b0;
    step(1);
    i_start = 1'b1;
    step(1);
    push("restart_state", SelState, 1);
    push("restart_sl", SelSl, 0);
    push("restart_sr", SelSr, 0);
    push("restart_win", SelWin, 0);
    push("restart_brst", SelBrst, 1);
    drain();

    // Reset in the middle of a point countdown.
    strobe(60);
    i_bx1 = 12'd2;
    strobe(1);
    i_bx1 = 12'd300;
    push("pre_rst_state", SelState, 3);
    push("pre_rst_sr", SelSr, 1);
    drain();
    strobe(10);
    i_start = 1'b0;
    i_rst   = 1'b1;
    step(1);
    i_rst = 1'b0;
    push("rst_point_state", SelState, 0);
    push("rst_point_sr", SelSr, 0);
    push("rst_point_sl", SelSl, 0);
    push("rst_point_win", SelWin, 0);
    push("rst_point_anim", SelAnim, 0);
    push("rst_point_brst", SelBrst, 0);
    drain();

    // Reset coincident with a miss strobe wins over the score update.
    i_start = 1'b1;
    step(1);
    strobe(60);
    push("pre_rst2_state", SelState, 2);
    drain();
    i_bx1     = 12'd2;
    i_ani_stb = 1'b1;
    i_rst     = 1'b1;
    i_start   = 1'b0;
    step(1);
    i_ani_stb = 1'b0;
    i_rst     = 1'b0;
    i_bx1     = 12'd300;
    push("rst_miss_state", SelState, 0);
    push("rst_miss_sr", SelSr, 0);
    push("rst_miss_anim", SelAnim, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
